// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply controller.
package matmul_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StClr,
        StMac,
        StDrain,
        StWrite,
        StOutRd,
        StOut,
        StFin
    } state_e;

    function automatic int unsigned res_width(input int unsigned dw);
        return 2 * dw + 2;
    endfunction

    // Byte beats needed to move one result element out.
    function automatic int unsigned num_beats(input int unsigned dw);
        return (res_width(dw) + dw - 1) / dw;
    endfunction

    localparam int unsigned RES_W     = res_width(8);
    localparam int unsigned NUM_BEATS = num_beats(8);

endpackage

// File: rtl/matmul_controller_if.sv
// Handshake, memory-control and address bundle between the sequencer and the datapath.
interface matmul_controller_if #(
    parameter int unsigned M = 8,
    parameter int unsigned N = 8
);
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic           out_ready;
    logic           out_valid;
    logic           busy;
    logic           done;
    logic           m1EN, m1rEN, m1wEN;
    logic           m2EN, m2rEN, m2wEN;
    logic           m3EN, m3rEN, m3wEN;
    logic           mult_ld;
    logic           mult_rst;
    logic [M+N-1:0] addr1, addr2, addr3;
    logic [1:0]     shift_cnt;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, out_valid, busy, done,
        output m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
        output mult_ld, mult_rst, addr1, addr2, addr3, shift_cnt
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, out_valid, busy, done,
        input  m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN,
        input  mult_ld, mult_rst, addr1, addr2, addr3, shift_cnt
    );
endinterface

// File: rtl/matmul_controller_idx_counter.sv
// Nested i/j/k index counter: k steps on its own, (i,j) steps with j fastest.
module idx_counter #(
    parameter int unsigned IW = 8,
    parameter int unsigned JW = 8,
    parameter int unsigned KW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          k_en_i,
    input  logic          ij_en_i,
    output logic [IW-1:0] i_o,
    output logic [JW-1:0] j_o,
    output logic [KW-1:0] k_o,
    output logic          k_last_o,
    output logic          ij_last_o
);
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else begin
            if (k_en_i) k_d = k_q + KW'(1);
            if (ij_en_i) begin
                j_d = j_q + JW'(1);
                if (&j_q) i_d = i_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign i_o       = i_q;
    assign j_o       = j_q;
    assign k_o       = k_q;
    assign k_last_o  = &k_q;
    assign ij_last_o = &{i_q, j_q};
endmodule

// File: rtl/matmul_controller.sv
// Sequencer for the matrix-multiply datapath: load A and B, compute C = A x B, stream C out.
module matmul_controller
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned M          = 8,
    parameter int unsigned N          = 8
) (
    input logic                clk,
    input logic                rst,
    matmul_controller_if.master bus
);
    localparam int unsigned AW       = M + N;
    localparam logic [1:0]  LastBeat = 2'(num_beats(DATA_WIDTH) - 1);

    state_e         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [1:0]     beat_q, beat_d;
    logic           clr, k_en, ij_en, k_last, ij_last;
    logic [M-1:0]   i, j;
    logic [N-1:0]   k;

    logic ld_a_q, ld_b_q, mac_q, wr3_q, rd3_q;
    logic mult_rst_q, mult_ld_q, out_valid_q, done_q, busy_q;

    idx_counter #(
        .IW(M),
        .JW(M),
        .KW(N)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .k_en_i   (k_en),
        .ij_en_i  (ij_en),
        .i_o      (i),
        .j_o      (j),
        .k_o      (k),
        .k_last_o (k_last),
        .ij_last_o(ij_last)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        clr     = 1'b0;
        k_en    = 1'b0;
        ij_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoadA;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            StLoadA, StLoadB: begin
                if (bus.in_valid) begin
                    cnt_d = cnt_q + AW'(1);
                    if (&cnt_q) state_d = (state_q == StLoadA) ? StLoadB : StClr;
                end
            end
            StClr: begin
                clr     = 1'b1;
                state_d = StMac;
            end
            StMac: begin
                k_en = 1'b1;
                if (k_last) state_d = StDrain;
            end
            StDrain: state_d = StWrite;
            StWrite: begin
                ij_en   = 1'b1;
                state_d = ij_last ? StOutRd : StMac;
            end
            StOutRd: state_d = StOut;
            StOut: begin
                if (bus.out_ready) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = 2'd0;
                        ij_en   = 1'b1;
                        state_d = ij_last ? StFin : StOutRd;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control flags are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            beat_q      <= 2'd0;
            ld_a_q      <= 1'b0;
            ld_b_q      <= 1'b0;
            mac_q       <= 1'b0;
            wr3_q       <= 1'b0;
            rd3_q       <= 1'b0;
            mult_rst_q  <= 1'b0;
            mult_ld_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            ld_a_q      <= (state_d == StLoadA);
            ld_b_q      <= (state_d == StLoadB);
            mac_q       <= (state_d == StMac);
            wr3_q       <= (state_d == StWrite);
            rd3_q       <= (state_d == StOutRd);
            mult_rst_q  <= (state_d == StClr) || (state_d == StWrite);
            // The first MAC cycle of an element has no product ready yet.
            mult_ld_q   <= ((state_d == StMac) && (state_q == StMac)) || (state_d == StDrain);
            out_valid_q <= (state_d == StOut);
            done_q      <= (state_d == StFin);
            busy_q      <= (state_d != StIdle);
        end
    end

    // Load writes follow in_valid directly so the byte on data_in is the one captured.
    assign bus.in_ready  = ld_a_q | ld_b_q;
    assign bus.m1wEN     = ld_a_q & bus.in_valid;
    assign bus.m1rEN     = mac_q;
    assign bus.m1EN      = bus.m1wEN | mac_q;
    assign bus.m2wEN     = ld_b_q & bus.in_valid;
    assign bus.m2rEN     = mac_q;
    assign bus.m2EN      = bus.m2wEN | mac_q;
    assign bus.m3wEN     = wr3_q;
    assign bus.m3rEN     = rd3_q;
    assign bus.m3EN      = wr3_q | rd3_q;
    assign bus.mult_rst  = mult_rst_q;
    assign bus.mult_ld   = mult_ld_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.shift_cnt = beat_q;
    assign bus.addr1     = ld_a_q ? cnt_q : {i, k};
    assign bus.addr2     = ld_b_q ? cnt_q : {k, j};
    assign bus.addr3     = AW'({i, j});
endmodule

// File: tb/tb_matmul_controller.sv
// Directed bench: drives the controller against a small datapath model with M = N = 2.
module tb_matmul_controller;
    localparam int unsigned M  = 2;
    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matmul_controller_if #(.M(M), .N(N)) bus ();

    matmul_controller #(
        .DATA_WIDTH(DW),
        .M         (M),
        .N         (N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Datapath model: synchronous memories and the 18-bit accumulator.
    logic [7:0]  data_in;
    logic [7:0]  mat1 [16];
    logic [7:0]  mat2 [16];
    logic [17:0] mat3 [16];
    logic [7:0]  d1, d2;
    logic [17:0] d3;
    logic [17:0] acc = '0;
    logic [7:0]  out_byte;

    int cyc = 0, clr_cyc = 0, comp_len = 0, ld_cnt = 0, ld_bad = 0;
    int w1_cnt = 0, w2_cnt = 0, rd3_cnt = 0, done_cnt = 0, rst_cnt = 0;
    bit rd_pend = 1'b0;
    logic [3:0] w1q [$];
    logic [3:0] w2q [$];
    logic [7:0] gotq [$];

    always_comb begin
        out_byte = d3[7:0];
        if (bus.shift_cnt == 2'd1) out_byte = d3[15:8];
        else if (bus.shift_cnt == 2'd2) out_byte = {6'd0, d3[17:16]};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.m1EN && bus.m1wEN) begin
            mat1[bus.addr1] <= data_in;
            w1q.push_back(bus.addr1);
            w1_cnt <= w1_cnt + 1;
        end
        if (bus.m1EN && bus.m1rEN) d1 <= mat1[bus.addr1];
        if (bus.m2EN && bus.m2wEN) begin
            mat2[bus.addr2] <= data_in;
            w2q.push_back(bus.addr2);
            w2_cnt <= w2_cnt + 1;
        end
        if (bus.m2EN && bus.m2rEN) d2 <= mat2[bus.addr2];
        if (bus.mult_rst) acc <= '0;
        else if (bus.mult_ld) acc <= acc + ({10'd0, d1} * {10'd0, d2});
        if (bus.m3EN && bus.m3wEN) mat3[bus.addr3] <= acc;
        if (bus.m3EN && bus.m3rEN) begin
            d3 <= mat3[bus.addr3];
            rd3_cnt <= rd3_cnt + 1;
            if (rd_pend) begin
                comp_len <= cyc - clr_cyc;
                rd_pend  <= 1'b0;
            end
        end
        if (bus.mult_rst && !bus.m3wEN) begin
            clr_cyc <= cyc;
            rd_pend <= 1'b1;
        end
        if (bus.mult_rst) begin
            rst_cnt <= rst_cnt + 1;
            if ((bus.m3wEN && ld_cnt != 4) || bus.mult_ld) ld_bad <= ld_bad + 1;
            ld_cnt <= 0;
        end else begin
            if (bus.m3wEN) ld_bad <= ld_bad + 1;
            if (bus.mult_ld) ld_cnt <= ld_cnt + 1;
        end
        if (bus.out_valid && bus.out_ready) gotq.push_back(out_byte);
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] a_v [16];
    logic [7:0] b_v [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ref_c(input int i, input int j);
        logic [17:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + {10'd0, a_v[i*4+k]} * {10'd0, b_v[k*4+j]};
        return s;
    endfunction

    task automatic feed(input bit gaps);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check("in_ready_after_start", bus.in_ready, 1);
        for (int n = 0; n < 32; n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            data_in = (n < 16) ? a_v[n] : b_v[n-16];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("in_ready_after_load", bus.in_ready, 0);
    endtask

    task automatic run_job(input bit gaps, input bit stall, input bit noise);
        int w1b, w2b, q1b, q2b, gb, db, lbb, rb, r3b, t, rsnap;
        logic [7:0] snap;
        logic [17:0] c;
        w1b = w1_cnt; w2b = w2_cnt; q1b = w1q.size(); q2b = w2q.size();
        gb = gotq.size(); db = done_cnt; lbb = ld_bad; rb = rst_cnt; r3b = rd3_cnt;
        feed(gaps);
        if (noise) begin
            bus.in_valid = 1'b1;
            @(negedge clk) bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
            check("busy_during_compute", bus.busy, 1);
            check("in_ready_during_compute", bus.in_ready, 0);
        end
        if (stall) begin
            t = 0;
            while (!(bus.out_valid && bus.shift_cnt == 2'd1) && t < 300) begin
                @(negedge clk);
                t++;
            end
            check("stall_reach", {bus.out_valid, bus.shift_cnt}, 3'b101);
            bus.out_ready = 1'b0;
            snap = out_byte;
            rsnap = rd3_cnt;
            repeat (5) begin
                @(negedge clk);
                check("stall_valid", bus.out_valid, 1);
                check("stall_shift", bus.shift_cnt, 1);
                check("stall_byte", out_byte, snap);
                check("stall_no_read", rd3_cnt, rsnap);
            end
            bus.out_ready = 1'b1;
        end
        t = 0;
        while (!bus.done && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", bus.done, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_after_fin", bus.busy, 0);
        check("done_once", done_cnt - db, 1);
        check("w1_count", w1_cnt - w1b, 16);
        check("w2_count", w2_cnt - w2b, 16);
        for (int n = 0; n < 16; n++) begin
            check("w1_addr", w1q[q1b+n], n);
            check("w2_addr", w2q[q2b+n], n);
        end
        check("mult_ld_per_elem", ld_bad - lbb, 0);
        check("mult_rst_count", rst_cnt - rb, 17);
        check("rd3_count", rd3_cnt - r3b, 16);
        check("compute_len", comp_len, 97);
        check("beat_count", gotq.size() - gb, 48);
        for (int e = 0; e < 16; e++) begin
            c = ref_c(e / 4, e % 4);
            check("beat0", gotq[gb+3*e], c[7:0]);
            check("beat1", gotq[gb+3*e+1], c[15:8]);
            check("beat2", gotq[gb+3*e+2], {6'd0, c[17:16]});
        end
    endtask

    initial begin
        int gb, t;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        data_in       = 8'd0;

        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_m1EN", bus.m1EN, 0);
        check("rst_m3wEN", bus.m3wEN, 0);
        check("rst_mult_rst", bus.mult_rst, 0);
        check("rst_mult_ld", bus.mult_ld, 0);
        check("rst_addr1", bus.addr1, 0);
        check("rst_addr3", bus.addr3, 0);
        check("rst_shift", bus.shift_cnt, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        // Identity times 0..15: C equals B.
        for (int n = 0; n < 16; n++) begin
            a_v[n] = (n / 4 == n % 4) ? 8'd1 : 8'd0;
            b_v[n] = 8'(n);
        end
        gb = gotq.size();
        run_job(1'b0, 1'b0, 1'b0);
        check("ident_e5_b0", gotq[gb+15], 8'd5);
        check("ident_e5_b1", gotq[gb+16], 8'd0);
        check("ident_e15_b0", gotq[gb+45], 8'd15);

        // Full-scale operands: every element is 4*255*255 = 0x3F804.
        for (int n = 0; n < 16; n++) begin
            a_v[n] = 8'hFF;
            b_v[n] = 8'hFF;
        end
        gb = gotq.size();
        run_job(1'b0, 1'b0, 1'b0);
        check("full_e0_b0", gotq[gb], 8'h04);
        check("full_e0_b1", gotq[gb+1], 8'hF8);
        check("full_e0_b2", gotq[gb+2], 8'h03);
        check("full_e15_b1", gotq[gb+46], 8'hF8);

        // Random data, load gaps, output stall, stray start/in_valid while busy.
        for (int n = 0; n < 16; n++) begin
            a_v[n] = 8'($urandom_range(0, 255));
            b_v[n] = 8'($urandom_range(0, 255));
        end
        run_job(1'b1, 1'b1, 1'b1);

        // Reset during MAC aborts the job asynchronously.
        feed(1'b0);
        t = 0;
        while (!bus.m1rEN && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("mac_reached", bus.m1rEN, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_m1EN", bus.m1EN, 0);
        check("arst_m2rEN", bus.m2rEN, 0);
        check("arst_mult_ld", bus.mult_ld, 0);
        check("arst_addr1", bus.addr1, 0);
        check("arst_addr2", bus.addr2, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", bus.busy, 0);

        // A fresh job after reset reloads both matrices.
        for (int n = 0; n < 16; n++) begin
            a_v[n] = (n / 4 == n % 4) ? 8'd1 : 8'd0;
            b_v[n] = 8'(16 - n);
        end
        run_job(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/matmul_controller.md
Name: matmul_controller

Overview:
- Sequencer for the matrix-multiply datapath (two operand memories, MAC register, 18-bit result memory).
- Streams operand A (2^M x 2^N) then B (2^N x 2^M) from a byte input into mat1/mat2.
- Computes C = A x B by driving memory enables, addresses, mult_ld and mult_rst.
- Streams every C element out as three byte beats selected by shift_cnt.

Parameters:
- DATA_WIDTH, 8, operand byte width; the result is 2*DATA_WIDTH+2 bits.
- M, 8, row-address bits of A; A has 2^M rows and C is 2^M x 2^M.
- N, 8, inner-dimension address bits; A has 2^N columns. N >= M is required.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- in_valid  in  1  an input byte is present (the byte itself goes straight to the datapath data_in).
- in_ready  out  1  controller accepts a byte this cycle.
- out_ready  in  1  consumer accepts the current output beat.
- out_valid  out  1  the result beat selected by shift_cnt is valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output beat.
- m1EN,m1rEN,m1wEN  out  1 each  mat1 RAM enable, read enable, write enable.
- m2EN,m2rEN,m2wEN  out  1 each  mat2 RAM enable, read enable, write enable.
- m3EN,m3rEN,m3wEN  out  1 each  mat3 RAM enable, read enable, write enable.
- mult_ld  out  1  accumulator load.
- mult_rst  out  1  accumulator clear.
- addr1,addr2,addr3  out  M+N each  memory addresses.
- shift_cnt  out  2  byte select of the 18-bit result (0 = bits 7:0, 1 = bits 15:8, 2 = bits 17:16).

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE; all counters clear.
  - Every output is 0, including in_ready, out_valid, done, all enables and all addresses.
- Memory timing:
  - Memories read synchronously: data_out is valid in the cycle after xEN & xrEN.
  - Writes occur at the edge ending a cycle with xEN & xwEN.
  - mult_rst has priority over mult_ld.
- Addressing:
  - addr1 = {i,k} (row i, column k).
  - addr2 = {k,j}.
  - addr3 = i*2^M + j, zero-extended to M+N bits.
  - Enables are high only in cycles that access that memory.
- State machine:
  - IDLE: when start=1, go to LOAD_A with the load counter at 0.
  - LOAD_A: in_ready=1.
    - Each in_valid&in_ready cycle writes the byte with m1EN=m1wEN=1 at addr1 = counter (row-major order).
    - After 2^(M+N) beats, go to LOAD_B.
    - in_valid gaps stall the counter; nothing is written during a gap.
  - LOAD_B: identical to LOAD_A but on mat2; then go to CLR.
  - CLR: one cycle, mult_rst=1, i=j=k=0.
  - MAC: 2^N cycles.
    - Each cycle issues a read of both operands at k (m1EN=m1rEN=m2EN=m2rEN=1).
    - mult_ld=1 in every MAC cycle except the first; it loads the product of the previous k.
    - k increments each cycle; the last cycle goes to DRAIN.
  - DRAIN: mult_ld=1 for the final product; no reads.
  - WRITE: m3EN=m3wEN=1 at addr3(i,j) and mult_rst=1 in the same cycle.
    - The stored value is the completed sum; the clear takes effect afterwards.
    - Advance (i,j) with j fastest: more elements go to MAC, last element goes to OUT_RD.
  - Cost per element: 2^N+2 cycles. Compute-phase total: 1 + 2^(2M)*(2^N+2) cycles.
  - OUT_RD: m3EN=m3rEN=1 at addr3(i,j); go to OUT.
  - OUT: out_valid=1 with shift_cnt = 0, 1, 2 in turn.
    - A beat advances only when out_ready=1; out_valid, shift_cnt and the mat3 read data hold while out_ready=0.
    - mat3 is not re-enabled in this state.
    - After beat 2 is accepted: more elements go to OUT_RD; the last element goes to FIN.
  - FIN: done=1 for one cycle; go to IDLE.
- Boundary conditions:
  - start is ignored outside IDLE.
  - in_valid is ignored outside LOAD_A/LOAD_B.
  - The 18-bit accumulator cannot overflow for N <= 2 with full-scale operands; for larger N the sum wraps modulo 2^18 (datapath width).
  - Reset mid-operation aborts immediately; a new start reloads both matrices.

Decomposition:
- Package matmul_pkg:
  - state enum (IDLE, LOAD_A, LOAD_B, CLR, MAC, DRAIN, WRITE, OUT_RD, OUT, FIN);
  - RES_W = 2*DATA_WIDTH+2;
  - NUM_BEATS = 3.
- One sub-module, idx_counter: a parameterised nested i/j/k counter with clear, enable and last-flags.

Test Plan:
- M=N=2; A=identity, B=0..15 -> C bytes per element are (b,0,0) in row-major order 0..15; done pulses once; compute phase is 97 cycles from CLR to OUT_RD.
- A=B=all 255, M=N=2 -> every element equals 260100 = 0x3F804; beats are 0x04, 0xF8, 0x03.
- Random in_valid gaps during load -> exactly 16 writes per matrix with consecutive addresses; result matches the reference model.
- out_ready low for 5 cycles on beat 1 -> out_valid and shift_cnt=1 stay high and stable; no extra mat3 read; the sequence resumes intact.
- rst asserted mid-MAC -> all outputs 0 asynchronously; after release, busy=0; a start pulse during busy is ignored.
- Check every cycle that mult_rst=1 in CLR and WRITE and that mult_ld=1 exactly 2^N times per element.
